// File: rtl/serial_link_flit_splitter.sv
// Data-link TX stage: splits one wide protocol-layer payload into narrow flits,
// dropping trailing all-zero flits (at least one flit is always sent).
module serial_link_flit_splitter #(
    parameter  int PayloadWidth = 512,
    parameter  int FlitWidth    = 64,
    localparam int NumFlits     = (PayloadWidth + FlitWidth - 1) / FlitWidth,
    localparam int FlitIdxW     = (NumFlits > 1) ? $clog2(NumFlits) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [PayloadWidth-1:0] payload_i,
    input  logic                    payload_valid_i,
    output logic                    payload_ready_o,
    output logic [FlitWidth-1:0]    flit_o,
    output logic                    flit_valid_o,
    input  logic                    flit_ready_i,
    output logic [FlitIdxW-1:0]     flit_idx_o,
    output logic                    flit_last_o,
    output logic                    busy_o
);

    localparam int ExtW = NumFlits * FlitWidth;

    typedef logic [NumFlits-1:0][FlitWidth-1:0] flit_vec_t;

    typedef enum logic {
        Idle = 1'b0,
        Send = 1'b1
    } state_e;

    state_e                state_q, state_d;
    flit_vec_t             payload_q;
    logic [FlitIdxW-1:0]   cnt_q;
    // Holds the packet length minus one, i.e. the index of the last flit to send.
    logic [FlitIdxW-1:0]   last_idx_q;

    logic [ExtW-1:0]       payload_wide;
    flit_vec_t             payload_ext;
    logic                  accept;
    logic                  advance;
    logic                  drain;
    logic                  is_last;

    assign payload_wide = ExtW'(payload_i);
    assign payload_ext  = payload_wide;

    function automatic logic [FlitIdxW-1:0] last_nonzero(input flit_vec_t f);
        last_nonzero = '0;
        for (int k = 0; k < NumFlits; k++) begin
            if (|f[k]) last_nonzero = FlitIdxW'(k);
        end
    endfunction

    assign is_last = (state_q == Send) && (cnt_q == last_idx_q);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        drain   = 1'b0;
        case (state_q)
            Idle: begin
                if (payload_valid_i) begin
                    accept  = 1'b1;
                    state_d = Send;
                end
            end
            Send: begin
                if (flit_ready_i) begin
                    if (!is_last) begin
                        advance = 1'b1;
                    end else if (payload_valid_i) begin
                        accept = 1'b1;
                    end else begin
                        drain   = 1'b1;
                        state_d = Idle;
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= Idle;
            // NOTE: the payload holding register is reset too, so flit_o shows
            // zero rather than X before the first packet.
            payload_q  <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                payload_q  <= payload_ext;
                last_idx_q <= last_nonzero(payload_ext);
                cnt_q      <= '0;
            end else if (advance) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (drain) begin
                cnt_q <= '0;
            end
        end
    end

    // The back-to-back accept is the only output that looks at flit_ready_i.
    assign payload_ready_o = (state_q == Idle) || (is_last && flit_ready_i);
    assign flit_valid_o    = (state_q == Send);
    assign flit_o          = payload_q[cnt_q];
    assign flit_idx_o      = cnt_q;
    assign flit_last_o     = is_last;
    assign busy_o          = (state_q == Send);

endmodule

// File: tb/tb_serial_link_flit_splitter.sv
// Self-checking bench for serial_link_flit_splitter: directed table, multi-cycle
// corner sequences and a randomized zero-fill reassembly scoreboard.
module tb_serial_link_flit_splitter;

    localparam int PW = 200;
    localparam int FW = 64;
    localparam int NF = 4;
    localparam int IW = 2;
    localparam int EW = NF * FW;
    localparam int NUM_RAND = 10000;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [PW-1:0] payload_i;
    logic          payload_valid_i;
    logic          payload_ready_o;
    logic [FW-1:0] flit_o;
    logic          flit_valid_o;
    logic          flit_ready_i;
    logic [IW-1:0] flit_idx_o;
    logic          flit_last_o;
    logic          busy_o;

    serial_link_flit_splitter #(.PayloadWidth(PW), .FlitWidth(FW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .payload_i       (payload_i),
        .payload_valid_i (payload_valid_i),
        .payload_ready_o (payload_ready_o),
        .flit_o          (flit_o),
        .flit_valid_o    (flit_valid_o),
        .flit_ready_i    (flit_ready_i),
        .flit_idx_o      (flit_idx_o),
        .flit_last_o     (flit_last_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference length: scan from the top flit down for the first non-zero one.
    function automatic int ref_len(input logic [PW-1:0] p);
        logic [EW-1:0] e;
        e = EW'(p);
        for (int k = NF - 1; k >= 0; k--) begin
            if (e[k*FW +: FW] != '0) return k + 1;
        end
        return 1;
    endfunction

    typedef struct {
        logic [PW-1:0] payload;
        int            len;
    } exp_t;

    typedef struct {
        logic [PW-1:0] payload;
        int            len;
        logic [FW-1:0] last_data;
    } vec_t;

    exp_t          exp_q[$];
    logic [EW-1:0] asm_q = '0;
    int            nflit = 0;
    int            rx_pkts = 0;
    int            tx_pkts = 0;
    logic          have_prev = 1'b0;
    logic [FW-1:0] prev_flit;
    logic [IW-1:0] prev_idx;
    logic          prev_last;

    // Monitor: AXIS stability, index sequencing and zero-fill reassembly.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            asm_q     = '0;
            nflit     = 0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                check("stall_valid", flit_valid_o, 1'b1);
                check("stall_data", flit_o, prev_flit);
                check("stall_idx", flit_idx_o, prev_idx);
                check("stall_last", flit_last_o, prev_last);
            end
            have_prev = flit_valid_o && !flit_ready_i;
            prev_flit = flit_o;
            prev_idx  = flit_idx_o;
            prev_last = flit_last_o;
            if (flit_valid_o && flit_ready_i) begin
                check("sb_idx", flit_idx_o, nflit);
                if (nflit < NF) asm_q[nflit*FW +: FW] = flit_o;
                nflit++;
                if (flit_last_o) begin
                    check("sb_has_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("sb_payload", asm_q, EW'(e.payload));
                        check("sb_len", nflit, e.len);
                    end
                    asm_q = '0;
                    nflit = 0;
                    rx_pkts++;
                end else if (nflit >= NF) begin
                    check("sb_overrun", nflit, NF - 1);
                    nflit = 0;
                end
            end
            if (payload_valid_i && payload_ready_o) begin
                exp_q.push_back('{payload: payload_i, len: ref_len(payload_i)});
                tx_pkts++;
            end
        end
    end

    logic rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            flit_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Returns at posedge+1 after the accepting edge, with payload_valid_i low.
    task automatic wait_accept(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!payload_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check({name, "_accept_timeout"}, t, 0);
        @(posedge clk);
        #1;
        payload_valid_i = 1'b0;
    endtask

    task automatic send_vec(input string name, input vec_t v);
        logic [EW-1:0] ext;
        ext = EW'(v.payload);
        // NOTE: inputs are driven with blocking assignments just after the edge.
        payload_i       = v.payload;
        payload_valid_i = 1'b1;
        flit_ready_i    = 1'b1;
        wait_accept(name);
        for (int k = 0; k < v.len; k++) begin
            @(negedge clk);
            check({name, "_valid"}, flit_valid_o, 1'b1);
            check({name, "_idx"}, flit_idx_o, k);
            check({name, "_last"}, flit_last_o, k == v.len - 1);
            if (k == v.len - 1) check({name, "_last_data"}, flit_o, v.last_data);
            else                check({name, "_data"}, flit_o, ext[k*FW +: FW]);
        end
        @(negedge clk);
        check({name, "_idle_valid"}, flit_valid_o, 1'b0);
        check({name, "_idle_ready"}, payload_ready_o, 1'b1);
        check({name, "_idle_busy"}, busy_o, 1'b0);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[7];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EW-1:0] r;
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        int            t;
        int            keep;

        tbl[0] = '{{8'hA5, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC}, 4, 64'h0000_0000_0000_00A5};
        tbl[1] = '{200'h1234, 1, 64'h1234};
        tbl[2] = '{200'h0, 1, 64'h0};
        tbl[3] = '{200'h1 << 64, 2, 64'h1};
        tbl[4] = '{200'h1 << 191, 3, 64'h8000_0000_0000_0000};
        tbl[5] = '{200'h1 << 192, 4, 64'h1};
        tbl[6] = '{200'h1 << 63, 1, 64'h8000_0000_0000_0000};

        rst_i           = 1'b1;
        payload_i       = '0;
        payload_valid_i = 1'b0;
        flit_ready_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_valid", flit_valid_o, 1'b0);
        check("rst_idx", flit_idx_o, 0);
        check("rst_last", flit_last_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", payload_ready_o, 1'b1);
        check("rst_flit", flit_o, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) send_vec($sformatf("vec%0d", i), tbl[i]);

        // Back-to-back: len 2 then len 3 with valid held and ready high.
        pa = (200'h1 << 64) | 200'h5;
        pb = 200'h1 << 130;
        payload_i       = pa;
        payload_valid_i = 1'b1;
        flit_ready_i    = 1'b1;
        wait_accept("b2b_a");
        payload_i       = pb;
        payload_valid_i = 1'b1;
        @(negedge clk);
        check("b2b_a0_valid", flit_valid_o, 1'b1);
        check("b2b_a0_idx", flit_idx_o, 0);
        check("b2b_a0_pready", payload_ready_o, 1'b0);
        @(negedge clk);
        check("b2b_a1_idx", flit_idx_o, 1);
        check("b2b_a1_last", flit_last_o, 1'b1);
        check("b2b_a1_pready", payload_ready_o, 1'b1);
        @(posedge clk);
        #1;
        payload_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b2b_b_valid", flit_valid_o, 1'b1);
            check("b2b_b_idx", flit_idx_o, k);
            check("b2b_b_last", flit_last_o, k == 2);
        end
        @(negedge clk);
        check("b2b_idle", flit_valid_o, 1'b0);
        @(posedge clk);
        #1;

        // Stall: ready low for three cycles while idx 1 is presented.
        payload_i       = tbl[0].payload;
        payload_valid_i = 1'b1;
        flit_ready_i    = 1'b1;
        wait_accept("stall");
        @(negedge clk);
        check("stall_idx0", flit_idx_o, 0);
        @(posedge clk);
        #1;
        flit_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_hold_valid", flit_valid_o, 1'b1);
            check("stall_hold_idx", flit_idx_o, 1);
            check("stall_hold_data", flit_o, 64'h5555_6666_7777_8888);
            check("stall_hold_pready", payload_ready_o, 1'b0);
        end
        @(posedge clk);
        #1;
        flit_ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("stall_resume_idx", flit_idx_o, k);
            check("stall_resume_last", flit_last_o, k == 3);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset while idx 1 is on the link.
        payload_i       = tbl[0].payload;
        payload_valid_i = 1'b1;
        flit_ready_i    = 1'b1;
        wait_accept("arst");
        @(negedge clk);
        check("arst_idx0", flit_idx_o, 0);
        @(posedge clk);
        #2;
        check("arst_pre_idx", flit_idx_o, 1);
        rst_i = 1'b1;
        #1;
        check("arst_valid", flit_valid_o, 1'b0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_idx", flit_idx_o, 0);
        check("arst_last", flit_last_o, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("arst_rel_ready", payload_ready_o, 1'b1);
        check("arst_rel_valid", flit_valid_o, 1'b0);
        @(posedge clk);
        #1;
        send_vec("arst_next", tbl[0]);

        // Randomized scoreboard run with random downstream stalls.
        rx_pkts    = 0;
        tx_pkts    = 0;
        rand_ready = 1'b1;
        for (int p = 0; p < NUM_RAND; p++) begin
            for (int w = 0; w < EW / 32; w++) r[w*32 +: 32] = $urandom;
            keep = $urandom_range(0, NF);
            for (int k = 0; k < NF; k++) begin
                if (k >= keep || $urandom_range(0, 3) == 0) r[k*FW +: FW] = '0;
            end
            payload_i       = r[PW-1:0];
            payload_valid_i = 1'b1;
            wait_accept("rand");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        flit_ready_i = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy_o, 1'b0);
        check("rand_tx", tx_pkts, NUM_RAND);
        check("rand_rx", rx_pkts, NUM_RAND);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
